avlst_32to64_pack: RTL
======================

# avlst_32to64_pack

Single-clock Avalon-ST width converter that packs 32-bit packet beats into 64-bit packet beats, with SOP/EOP framing and empty-byte tracking. Sits on the ingress side of the unpack FIFO path, so 32-bit sources (DMA and framer outputs) can feed 64-bit packet FIFOs. It is the counterpart of the 64-to-32 unpacking FIFOs. It recovers from malformed framing without stalling.

## Interface
- DATA_WIDTH_IN, 32, input data width; fixed, ratio to output is exactly 2.
- DATA_WIDTH_OUT, 64, output data width; fixed.
- INDEX_WIDTH, 11, width of `dout_index`.
- DATA_BIG_ENDIAN, 1'b1, lane order: 1 puts the first input beat in `dout_data[63:32]`, 0 puts it in `[31:0]`.

Ports:
- clk  in  1  clock, posedge active.
- rst_n  in  1  reset; asynchronous, active-low.
- din_sop  in  1  input start of packet.
- din_eop  in  1  input end of packet.
- din_valid  in  1  input beat valid.
- din_data  in  32  input data.
- din_empty  in  2  input empty bytes; meaningful only with `din_eop`.
- din_ready  out  1  input ready.
- dout_ready  in  1  output ready.
- dout_sop  out  1  output start of packet.
- dout_eop  out  1  output end of packet.
- dout_valid  out  1  output beat valid.
- dout_data  out  64  output data.
- dout_empty  out  3  output empty bytes.
- dout_index  out  INDEX_WIDTH  64-bit beat index within the packet.
- error_cnt  out  32  framing error count.

## Operation
- Input acceptance: `acc = din_valid & din_ready`.
- `din_ready = ~dout_valid | dout_ready`. This is combinational and does not depend on `din_*`.
- State machine, states IDLE, LANE0, LANE1:
  - IDLE = outside a packet.
  - LANE0 = inside a packet, next beat goes to the first lane.
  - LANE1 = first lane is held in the half register, next beat goes to the second lane.
- IDLE:
  - `acc & din_sop & ~din_eop`: store the beat in the half register, latch the pending-SOP flag, go to LANE1.
  - `acc & din_sop & din_eop`: emit immediately with `dout_empty = 4 + din_empty`, `dout_sop = dout_eop = 1`; stay in IDLE.
  - `acc & ~din_sop`: drop the beat, count an error, stay in IDLE.
- LANE0: same as IDLE except SOP handling.
  - A beat without SOP starts the next 64-bit beat of the current packet.
  - A beat with SOP is a framing error: count it, then treat it as a new packet per IDLE rules.
- LANE1:
  - `acc & ~din_sop`: emit `{half, din_data}` (lane order per DATA_BIG_ENDIAN).
    - `dout_sop` = pending-SOP flag.
    - `dout_eop = din_eop`.
    - `dout_empty = din_eop ? din_empty : 0`.
    - Next state: IDLE if `din_eop`, else LANE0.
  - `acc & din_sop`: discard the half register, count an error, restart per IDLE rules with this beat.
- Unused lane of an early-EOP beat is driven to 0.
- `dout_index`:
  - 0 on the SOP beat.
  - +1 per emitted beat of the same packet.
  - Saturates at `2^INDEX_WIDTH-1`.
- Output register:
  - Loaded on emit.
  - `dout_valid` clears on `dout_ready` when no new emit occurs in the same cycle.
  - When both happen in one cycle, `dout_valid` stays 1 with the new contents.

## Timing
- Reset values:
  - `dout_valid`, `dout_sop`, `dout_eop` = 0.
  - `dout_data` = 0, `dout_empty` = 0, `dout_index` = 0.
  - `error_cnt` = 0.
  - State IDLE, half register cleared.
  - `din_ready` = 1.
- Latency: `dout_valid` rises the cycle after the edge that accepts the completing input beat.
- Throughput: full rate in, one 64-bit beat per 2 input beats. No bubbles while `dout_ready` is held 1.
- Backpressure: while `dout_valid & ~dout_ready`, `din_ready` = 0. The output is held stable, including a beat that is not accepted.
- An accepted beat in LANE1 with `din_sop` asserted is an error, even if `din_eop` is also asserted.
- Reset mid-packet: the partial half register and any pending output beat are discarded. `dout_valid` drops asynchronously.
- `error_cnt` wraps at 2^32.

## Configuration
- Macro `AVLST_32TO64_ERRCNT_EN`.
- Defined: `error_cnt` counts each framing error (orphan beat in IDLE, SOP in LANE0/LANE1). It increments once per accepted offending beat.
- Undefined: the counter logic is not built and `error_cnt` is tied to 0. Recovery behaviour is identical.

## Test plan
- Even packet: 4 beats 0x11111111..0x44444444, SOP on first, EOP on last, `din_empty` 0, big endian → 2 beats:
  - 0x1111111122222222, sop=1, idx 0.
  - 0x3333333344444444, eop=1, empty 0, idx 1.
- Odd packet: 3 beats, last with `din_empty`=1 → second output beat is 0x3333333300000000, eop=1, empty 5.
- Single-beat packet: SOP+EOP, `din_empty`=2 → one beat with sop=eop=1, empty 6. With DATA_BIG_ENDIAN=0 the data sits in `[31:0]`.
- Framing recovery:
  - Orphan beat in IDLE → no output, `error_cnt` 1.
  - SOP in LANE1 → half discarded, new packet emitted correctly, `error_cnt` 2.
  - Macro undefined → `error_cnt` stays 0.
- Backpressure: `dout_ready` 0 for 5 cycles mid-stream → `din_ready` 0, output held unchanged, no beats lost or duplicated. Random valid/ready over 1000 packets matches the reference model.
- Reset asserted while in LANE1 → all outputs at reset values. The next packet packs from lane 0 with `dout_index` 0.

Source files
------------

// File: rtl/avlst_32to64_pack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : avlst_32to64_pack                                             |
// | Purpose  : Avalon-ST width converter. Packs 32-bit packet beats into     |
// |            64-bit packet beats, with SOP/EOP framing and empty-byte      |
// |            tracking. Malformed framing is dropped or restarted without   |
// |            stalling the stream.                                          |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            din_sop/eop/valid/data[31:0]/empty[1:0] -> din_ready          |
// |            dout_sop/eop/valid/data[63:0]/empty[2:0]/index <- dout_ready  |
// |            error_cnt[31:0] : framing error count                         |
// | Options  : AVLST_32TO64_ERRCNT_EN builds the framing error counter;      |
// |            without it error_cnt is tied to 0.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module avlst_32to64_pack #(
  parameter int DATA_WIDTH_IN   = 32,
  parameter int DATA_WIDTH_OUT  = 64,
  parameter int INDEX_WIDTH     = 11,
  parameter bit DATA_BIG_ENDIAN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      din_sop,
  input  logic                      din_eop,
  input  logic                      din_valid,
  input  logic [DATA_WIDTH_IN-1:0]  din_data,
  input  logic [1:0]                din_empty,
  output logic                      din_ready,
  input  logic                      dout_ready,
  output logic                      dout_sop,
  output logic                      dout_eop,
  output logic                      dout_valid,
  output logic [DATA_WIDTH_OUT-1:0] dout_data,
  output logic [2:0]                dout_empty,
  output logic [INDEX_WIDTH-1:0]    dout_index,
  output logic [31:0]               error_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LANE0 = 2'd1,
    LANE1 = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [DATA_WIDTH_IN-1:0]   half_q, half_d;
  logic                       psop_q, psop_d;

  logic                       valid_q, valid_d;
  logic                       sop_q, sop_d;
  logic                       eop_q, eop_d;
  logic [DATA_WIDTH_OUT-1:0]  data_q, data_d;
  logic [2:0]                 empty_q, empty_d;
  logic [INDEX_WIDTH-1:0]     index_q, index_d;

  logic                       acc;
  logic                       start_pkt;
  logic                       err;
  logic                       emit;
  logic [DATA_WIDTH_IN-1:0]   e_first;
  logic [DATA_WIDTH_IN-1:0]   e_second;
  logic                       e_sop;
  logic                       e_eop;
  logic [2:0]                 e_empty;
  logic [DATA_WIDTH_OUT-1:0]  e_data;
  logic [INDEX_WIDTH-1:0]     index_inc;

  // Ready only depends on the output register, so upstream never sees a
  // combinational path from its own valid/data.
  assign din_ready = ~valid_q | dout_ready;
  assign acc       = din_valid & din_ready;

  // Framing decode: decides what the accepted beat does to the packing state
  // and whether it completes a 64-bit output beat.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    psop_d    = psop_q;
    start_pkt = 1'b0;
    err       = 1'b0;
    emit      = 1'b0;
    e_first   = '0;
    e_second  = '0;
    e_sop     = 1'b0;
    e_eop     = 1'b0;
    e_empty   = 3'd0;

    if (acc) begin
      unique case (state_q)
        IDLE: begin
          if (din_sop) begin
            start_pkt = 1'b1;
          end else begin
            // Orphan beat outside a packet: dropped.
            err = 1'b1;
          end
        end
        LANE0: begin
          if (din_sop) begin
            err       = 1'b1;
            start_pkt = 1'b1;
          end else if (din_eop) begin
            // Packet ends on the first lane: second lane is padding.
            emit     = 1'b1;
            e_first  = din_data;
            e_eop    = 1'b1;
            e_empty  = 3'd4 + {1'b0, din_empty};
            state_d  = IDLE;
          end else begin
            half_d  = din_data;
            psop_d  = 1'b0;
            state_d = LANE1;
          end
        end
        LANE1: begin
          if (din_sop) begin
            // Held half is abandoned; this beat opens a new packet.
            err       = 1'b1;
            start_pkt = 1'b1;
          end else begin
            emit     = 1'b1;
            e_first  = half_q;
            e_second = din_data;
            e_sop    = psop_q;
            e_eop    = din_eop;
            e_empty  = din_eop ? {1'b0, din_empty} : 3'd0;
            state_d  = din_eop ? IDLE : LANE0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (start_pkt) begin
        if (din_eop) begin
          emit    = 1'b1;
          e_first = din_data;
          e_sop   = 1'b1;
          e_eop   = 1'b1;
          e_empty = 3'd4 + {1'b0, din_empty};
          state_d = IDLE;
        end else begin
          half_d  = din_data;
          psop_d  = 1'b1;
          state_d = LANE1;
        end
      end
    end
  end

  generate
    if (DATA_BIG_ENDIAN) begin : g_big_endian
      assign e_data = {e_first, e_second};
    end else begin : g_little_endian
      assign e_data = {e_second, e_first};
    end
  endgenerate

  // A non-SOP emit always follows an earlier emit of the same packet, so the
  // output register already holds the previous index of this packet.
  assign index_inc = (index_q == {INDEX_WIDTH{1'b1}}) ? index_q
                                                       : index_q + INDEX_WIDTH'(1);

  always_comb begin
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    data_d  = data_q;
    empty_d = empty_q;
    index_d = index_q;
    if (emit) begin
      valid_d = 1'b1;
      sop_d   = e_sop;
      eop_d   = e_eop;
      data_d  = e_data;
      empty_d = e_empty;
      index_d = e_sop ? '0 : index_inc;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      half_q  <= '0;
      psop_q  <= 1'b0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      data_q  <= '0;
      empty_q <= 3'd0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      psop_q  <= psop_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      index_q <= index_d;
    end
  end

  assign dout_valid = valid_q;
  assign dout_sop   = sop_q;
  assign dout_eop   = eop_q;
  assign dout_data  = data_q;
  assign dout_empty = empty_q;
  assign dout_index = index_q;

`ifdef AVLST_32TO64_ERRCNT_EN
  logic [31:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 32'd0;
    end else if (err) begin
      err_cnt_q <= err_cnt_q + 32'd1;
    end
  end

  assign error_cnt = err_cnt_q;
`else
  // The error strobe is still decoded (recovery uses the same paths); it is
  // masked here so the counter output stays constant zero.
  assign error_cnt = {32{err & 1'b0}};
`endif

endmodule
`default_nettype wire
